// File: rtl/addsub_pkg.sv
// addsub_pkg: shared FSM state encoding and operation mode constants
package addsub_pkg;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;
endpackage

// File: rtl/addsub_unit.sv
// addsub_unit: combinational W-bit add/subtract, flag = carry (add) or no-borrow (sub)
// Ports: a, b operands; mode 0 = a + b, 1 = a - b; sum low W bits; flag bit W
module addsub_unit #(
  parameter int W = 3
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         mode,
  output logic [W-1:0] sum,
  output logic         flag
);
  // subtract as a + ~b + 1 so one adder serves both modes
  assign {flag, sum} = {1'b0, a} + {1'b0, b ^ {W{mode}}} + (W+1)'(mode);
endmodule

// File: rtl/addsub_arbiter.sv
// addsub_arbiter: two-requester round-robin front end for one shared add/sub unit
// Ports: clock, reset (async active-low); req_valid/req_ready, req_a0/req_b0/req_a1/req_b1,
//        req_mode per requester; rsp_valid/rsp_ready per requester; rsp_sum/rsp_flag shared
//        registered result; busy when not IDLE; op_count completed operations (wraps)
module addsub_arbiter
  import addsub_pkg::*;
#(
  parameter int W = 3
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [1:0]   req_valid,
  output logic [1:0]   req_ready,
  input  logic [W-1:0] req_a0,
  input  logic [W-1:0] req_a1,
  input  logic [W-1:0] req_b0,
  input  logic [W-1:0] req_b1,
  input  logic [1:0]   req_mode,
  output logic [1:0]   rsp_valid,
  input  logic [1:0]   rsp_ready,
  output logic [W-1:0] rsp_sum,
  output logic         rsp_flag,
  output logic         busy,
  output logic [7:0]   op_count
);
  state_t state, nxt;
  logic ptr, owner, gnt, acc, done, mode_q, flag_d;
  logic [W-1:0] a_q, b_q, sum_d;
  // pointer only matters on a tie; a lone requester always wins
  assign gnt  = &req_valid ? ptr : req_valid[1];
  assign acc  = state == IDLE && |req_valid;
  assign done = state == RESP && rsp_ready[owner];
  always_comb begin
    nxt       = acc ? EXEC : state == EXEC ? RESP : (state == RESP && !done) ? RESP : IDLE;
    req_ready = acc ? (gnt ? 2'b10 : 2'b01) : 2'b00;
    rsp_valid = state == RESP ? (owner ? 2'b10 : 2'b01) : 2'b00;
    busy      = state != IDLE;
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) state <= IDLE;
    else state <= nxt;
  addsub_unit #(.W(W)) u_unit (
    .a(a_q), .b(b_q), .mode(mode_q), .sum(sum_d), .flag(flag_d)
  );
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      ptr      <= 1'b0;
      owner    <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      mode_q   <= MODE_ADD;
      rsp_sum  <= '0;
      rsp_flag <= 1'b0;
      op_count <= 8'd0;
    end else begin
      if (acc) begin
        owner  <= gnt;
        a_q    <= gnt ? req_a1 : req_a0;
        b_q    <= gnt ? req_b1 : req_b0;
        mode_q <= req_mode[gnt];
      end
      if (state == EXEC) begin
        rsp_sum  <= sum_d;
        rsp_flag <= flag_d;
      end
      if (done) begin
        ptr      <= ~owner;
        op_count <= op_count + 8'd1;
      end
    end
endmodule

// File: tb/tb_addsub_arbiter.sv
// tb_addsub_arbiter: directed plus randomized checks against an arithmetic reference model
module tb_addsub_arbiter;
  import addsub_pkg::*;
  localparam int W = 3;
  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic [1:0]   req_valid = '0, req_mode = '0, rsp_ready = '0;
  logic [W-1:0] req_a0 = '0, req_a1 = '0, req_b0 = '0, req_b1 = '0;
  logic [1:0]   req_ready, rsp_valid;
  logic [W-1:0] rsp_sum;
  logic         rsp_flag, busy;
  logic [7:0]   op_count;
  int checks = 0, errors = 0, m_ptr = 0, m_cnt = 0;

  addsub_arbiter #(.W(W)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_a0(req_a0), .req_a1(req_a1), .req_b0(req_b0), .req_b1(req_b1),
    .req_mode(req_mode), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_sum(rsp_sum), .rsp_flag(rsp_flag), .busy(busy), .op_count(op_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // result as plain integers: add is a+b, subtract is 2^W + a - b (bit W set iff a >= b)
  function automatic int ref_res(input int a, input int b, input logic sub);
    return sub ? (1 << W) + a - b : a + b;
  endfunction

  task automatic run_op(input logic [1:0] v, input logic [W-1:0] a0, b0, a1, b1,
                        input logic [1:0] md, input int stall);
    int g, e;
    logic [1:0] gb;
    @(negedge clock);
    req_valid = v; req_a0 = a0; req_b0 = b0; req_a1 = a1; req_b1 = b1; req_mode = md;
    rsp_ready = 2'($urandom);
    #1;
    g  = (v == 2'b11) ? m_ptr : (v[1] ? 1 : 0);
    gb = (g == 1) ? 2'b10 : 2'b01;
    e  = ref_res(g == 1 ? int'(a1) : int'(a0), g == 1 ? int'(b1) : int'(b0), md[g]);
    chk("grant", int'(req_ready), int'(gb));
    chk("idle_busy", int'(busy), 0);
    chk("idle_rsp_valid", int'(rsp_valid), 0);
    @(negedge clock);
    req_valid = 2'($urandom); req_mode = 2'($urandom); rsp_ready = 2'($urandom);
    req_a0 = W'($urandom); req_b0 = W'($urandom); req_a1 = W'($urandom); req_b1 = W'($urandom);
    #1;
    chk("exec_busy", int'(busy), 1);
    chk("exec_req_ready", int'(req_ready), 0);
    chk("exec_rsp_valid", int'(rsp_valid), 0);
    for (int k = 0; k <= stall; k++) begin
      @(negedge clock);
      rsp_ready = (k == stall) ? (gb | (~gb & 2'($urandom))) : (~gb & 2'($urandom));
      req_valid = 2'($urandom);
      #1;
      chk("resp_rsp_valid", int'(rsp_valid), int'(gb));
      chk("resp_sum", int'(rsp_sum), e % (1 << W));
      chk("resp_flag", int'(rsp_flag), (e >> W) & 1);
      chk("resp_req_ready", int'(req_ready), 0);
      chk("resp_busy", int'(busy), 1);
    end
    @(negedge clock);
    req_valid = '0; rsp_ready = '0;
    #1;
    m_cnt++;
    m_ptr = 1 - g;
    chk("done_busy", int'(busy), 0);
    chk("done_rsp_valid", int'(rsp_valid), 0);
    chk("op_count", int'(op_count), m_cnt % 256);
  endtask

  initial begin
    repeat (3) @(negedge clock);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_rsp_valid", int'(rsp_valid), 0);
    chk("rst_sum", int'(rsp_sum), 0);
    chk("rst_flag", int'(rsp_flag), 0);
    chk("rst_op_count", int'(op_count), 0);
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("no_req_ready", int'(req_ready), 0);
    // abort an operation in EXEC; nothing should survive it
    @(negedge clock);
    req_valid = 2'b11; req_a0 = 3'd7; req_b0 = 3'd7; req_a1 = 3'd1; req_b1 = 3'd1; req_mode = 2'b00;
    #1;
    chk("abort_grant", int'(req_ready), 1);
    @(negedge clock);
    req_valid = '0;
    #1;
    chk("abort_exec_busy", int'(busy), 1);
    reset = 1'b0;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_rsp_valid", int'(rsp_valid), 0);
    chk("abort_op_count", int'(op_count), 0);
    chk("abort_sum", int'(rsp_sum), 0);
    @(negedge clock);
    #1;
    chk("abort_next_rsp_valid", int'(rsp_valid), 0);
    reset = 1'b1;
    m_ptr = 0;
    run_op(2'b01, 3'd5, 3'd3, 3'd0, 3'd0, {1'b0, MODE_ADD}, 0);
    run_op(2'b10, 3'd0, 3'd0, 3'd5, 3'd3, {MODE_SUB, 1'b0}, 0);
    run_op(2'b10, 3'd0, 3'd0, 3'd2, 3'd5, {MODE_SUB, 1'b0}, 0);
    for (int i = 0; i < 4; i++)
      run_op(2'b11, W'($urandom), W'($urandom), W'($urandom), W'($urandom), 2'($urandom), 0);
    run_op(2'($urandom_range(1, 3)), W'($urandom), W'($urandom), W'($urandom), W'($urandom),
           2'($urandom), 10);
    while (m_cnt < 256)
      run_op(2'($urandom_range(1, 3)), W'($urandom), W'($urandom), W'($urandom), W'($urandom),
             2'($urandom), $urandom_range(0, 2));
    chk("wrap", int'(op_count), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
